// File: rtl/dff_bank_test_sequencer.sv
// Four-phase stimulus/compare sequencer for a bank of CC_DFF cells sharing en/sr/d nets.
// Reports pass/fail plus the first failing phase and its mismatch mask.
module dff_bank_test_sequencer #(
  parameter int unsigned    N        = 64,
  parameter int unsigned    SETTLE   = 2,
  parameter logic           EN_ACT   = 1'b1,
  parameter logic           SR_ACT   = 1'b1,
  parameter logic [N-1:0]   EXP_SR   = '0,
  parameter logic [N-1:0]   EXP_HOLD = '0,
  parameter logic [N-1:0]   EXP_D0   = '0,
  parameter logic [N-1:0]   EXP_D1   = '1
) (
  input  logic         clk,
  input  logic         sr,
  input  logic         start,
  output logic         dut_en,
  output logic         dut_sr,
  output logic         dut_d,
  input  logic [N-1:0] dut_q,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [1:0]   fail_phase,
  output logic [N-1:0] fail_mask
);

  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  typedef enum logic [2:0] {StIdle, StPh0, StPh1, StPh2, StPh3, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            en_q, en_d, sr_q, sr_d, d_q, d_d;
  logic            busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic            failed_q, failed_d;
  logic [1:0]      fphase_q, fphase_d;
  logic [N-1:0]    fmask_q, fmask_d;

  logic [N-1:0]    exp_vec;
  logic [1:0]      phase_idx;
  logic            mismatch;
  logic            phase_end;

  always_comb begin
    exp_vec   = '0;
    phase_idx = 2'd0;
    case (state_q)
      StPh0:   begin exp_vec = EXP_SR;   phase_idx = 2'd0; end
      StPh1:   begin exp_vec = EXP_HOLD; phase_idx = 2'd1; end
      StPh2:   begin exp_vec = EXP_D0;   phase_idx = 2'd2; end
      StPh3:   begin exp_vec = EXP_D1;   phase_idx = 2'd3; end
      default: ;
    endcase
  end

  // Case inequality so X/Z on the bank output is reported as a mismatch in simulation.
  assign mismatch  = (dut_q !== exp_vec);
  assign phase_end = (cnt_q == CntW'(SETTLE));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    en_d     = en_q;
    sr_d     = sr_q;
    d_d      = d_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    failed_d = failed_q;
    fphase_d = fphase_q;
    fmask_d  = fmask_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StPh0;
          cnt_d    = '0;
          sr_d     = SR_ACT;
          en_d     = ~EN_ACT;
          d_d      = 1'b0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          failed_d = 1'b0;
          fphase_d = 2'd0;
          fmask_d  = '0;
        end
      end
      StPh0, StPh1, StPh2, StPh3: begin
        if (phase_end) begin
          cnt_d = '0;
          if (mismatch && !failed_q) begin
            failed_d = 1'b1;
            fphase_d = phase_idx;
            fmask_d  = dut_q ^ exp_vec;
          end
          case (state_q)
            StPh0: begin
              state_d = StPh1;
              sr_d    = ~SR_ACT;
              en_d    = ~EN_ACT;
              d_d     = 1'b1;
            end
            StPh1: begin
              state_d = StPh2;
              en_d    = EN_ACT;
              d_d     = 1'b0;
            end
            StPh2: begin
              state_d = StPh3;
              d_d     = 1'b1;
            end
            default: begin
              state_d = StDone;
              sr_d    = ~SR_ACT;
              en_d    = ~EN_ACT;
              d_d     = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              pass_d  = !(failed_q || mismatch);
            end
          endcase
        end else begin
          cnt_d = cnt_q + 1'b1;
          // Data toggles during the hold phase so a bank ignoring en is caught.
          if (state_q == StPh1) d_d = ~d_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge sr) begin
    if (sr) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      en_q     <= ~EN_ACT;
      sr_q     <= ~SR_ACT;
      d_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      failed_q <= 1'b0;
      fphase_q <= 2'd0;
      fmask_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      sr_q     <= sr_d;
      d_q      <= d_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      failed_q <= failed_d;
      fphase_q <= fphase_d;
      fmask_q  <= fmask_d;
    end
  end

  assign dut_en     = en_q;
  assign dut_sr     = sr_q;
  assign dut_d      = d_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_phase = fphase_q;
  assign fail_mask  = fmask_q;

endmodule

// File: tb/tb_dff_bank_test_sequencer.sv
// Directed bench: sequencer driving a small falling-edge DFF bank model, with injectable faults.
module tb_dff_bank_test_sequencer;

  logic       clk = 1'b0;
  logic       sr = 1'b1;
  logic       start = 1'b0;
  logic       inv_start = 1'b0;
  logic       dut_en, dut_sr, dut_d, busy, done, pass;
  logic [1:0] fail_phase;
  logic [3:0] fail_mask, q_main, bank_q;
  logic       inv_en, inv_sr, inv_d, inv_busy, inv_done, inv_pass;
  logic [1:0] inv_fphase;
  logic [3:0] inv_fmask, inv_q;
  int         mode = 0;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  dff_bank_test_sequencer #(
    .N(4), .SETTLE(2), .EN_ACT(1'b1), .SR_ACT(1'b1),
    .EXP_SR(4'b0000), .EXP_HOLD(4'b0000), .EXP_D0(4'b0000), .EXP_D1(4'b1111)
  ) u_dut (
    .clk(clk), .sr(sr), .start(start), .dut_en(dut_en), .dut_sr(dut_sr), .dut_d(dut_d),
    .dut_q(q_main), .busy(busy), .done(done), .pass(pass), .fail_phase(fail_phase),
    .fail_mask(fail_mask)
  );

  dff_bank_test_sequencer #(
    .N(4), .SETTLE(2), .EN_ACT(1'b0), .SR_ACT(1'b0),
    .EXP_SR(4'b0000), .EXP_HOLD(4'b0000), .EXP_D0(4'b0000), .EXP_D1(4'b1111)
  ) u_inv (
    .clk(clk), .sr(sr), .start(inv_start), .dut_en(inv_en), .dut_sr(inv_sr), .dut_d(inv_d),
    .dut_q(inv_q), .busy(inv_busy), .done(inv_done), .pass(inv_pass), .fail_phase(inv_fphase),
    .fail_mask(inv_fmask)
  );

  // Inverted-clock bank: mode 1 = bit 2 stuck at 1, mode 2 = enable ignored.
  always @(negedge clk) begin
    if (dut_sr) bank_q <= 4'b0000;
    else if (dut_en || mode == 2) bank_q <= {4{dut_d}};
  end
  assign q_main = (mode == 1) ? (bank_q | 4'b0100) : bank_q;

  always @(negedge clk) begin
    if (!inv_sr) inv_q <= 4'b0000;
    else if (!inv_en) inv_q <= {4{inv_d}};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns 1 ns after E0, the edge that samples start.
  task automatic pulse(input bit inv);
    @(negedge clk);
    if (inv) inv_start = 1'b1; else start = 1'b1;
    step();
    inv_start = 1'b0;
    start = 1'b0;
  endtask

  task automatic run_rest();
    for (int k = 1; k <= 12; k++) step();
  endtask

  initial begin
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_fphase", fail_phase, 0);
    check("rst_fmask", fail_mask, 0);
    check("rst_drive", {dut_en, dut_sr, dut_d}, 3'b000);
    check("rst_inv_drive", {inv_en, inv_sr, inv_d}, 3'b110);
    @(negedge clk);
    sr = 1'b0;

    // Ideal bank.
    pulse(1'b0);
    check("ideal_e0", {busy, done, pass}, 3'b100);
    check("ideal_ph0_drive", {dut_en, dut_sr, dut_d}, 3'b010);
    for (int k = 1; k <= 12; k++) begin
      step();
      case (k)
        3:  check("ideal_ph1_drive", {dut_en, dut_sr, dut_d}, 3'b001);
        4:  check("ideal_ph1_tog0", dut_d, 0);
        5:  check("ideal_ph1_tog1", dut_d, 1);
        6:  check("ideal_ph2_drive", {dut_en, dut_sr, dut_d}, 3'b100);
        9:  check("ideal_ph3_drive", {dut_en, dut_sr, dut_d}, 3'b101);
        11: check("ideal_e11", {busy, done}, 2'b10);
        12: begin
          check("ideal_done", {busy, done, pass}, 3'b011);
          check("ideal_fphase", fail_phase, 0);
          check("ideal_fmask", fail_mask, 0);
          check("ideal_idle_drive", {dut_en, dut_sr, dut_d}, 3'b000);
        end
        default: ;
      endcase
    end

    // Bit 2 stuck at 1: first failure in phase 0, not overwritten later.
    mode = 1;
    pulse(1'b0);
    check("stuck_done_drop", done, 0);
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 3) check("stuck_mask_ph0", fail_mask, 4'b0100);
    end
    check("stuck_pass", {done, pass}, 2'b10);
    check("stuck_fphase", fail_phase, 0);
    check("stuck_fmask", fail_mask, 4'b0100);

    // Enable ignored: bank follows toggling d in phase 1.
    mode = 2;
    pulse(1'b0);
    run_rest();
    check("noen_pass", {done, pass}, 2'b10);
    check("noen_fphase", fail_phase, 1);
    check("noen_fmask", fail_mask, 4'b1111);

    // Reset in phase 1, then a clean rerun.
    mode = 0;
    pulse(1'b0);
    repeat (4) step();
    sr = 1'b1;
    #1;
    check("midrst_state", {busy, done, pass}, 3'b000);
    check("midrst_fail", {fail_phase, fail_mask}, 6'd0);
    check("midrst_drive", {dut_en, dut_sr, dut_d}, 3'b000);
    @(negedge clk);
    sr = 1'b0;
    pulse(1'b0);
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 11) check("rerun_e11", {busy, done}, 2'b10);
    end
    check("rerun_done", {busy, done, pass}, 3'b011);

    // Start held for 20 cycles.
    @(negedge clk);
    start = 1'b1;
    step();
    for (int k = 1; k <= 25; k++) begin
      step();
      case (k)
        6:  check("hold_no_restart", {dut_en, dut_sr}, 2'b10);
        11: check("hold_e11", {busy, done}, 2'b10);
        12: check("hold_done", {busy, done, pass}, 3'b011);
        13: check("hold_restart", {busy, done, dut_sr}, 3'b101);
        19: start = 1'b0;
        24: check("hold_second_busy", {busy, done}, 2'b10);
        25: check("hold_second_done", {busy, done, pass}, 3'b011);
        default: ;
      endcase
    end

    // Active-low enable and set/reset polarity.
    pulse(1'b1);
    check("inv_ph0_drive", {inv_en, inv_sr}, 2'b10);
    for (int k = 1; k <= 12; k++) begin
      step();
      case (k)
        3:  check("inv_ph1_drive", {inv_en, inv_sr, inv_d}, 3'b111);
        6:  check("inv_ph2_drive", {inv_en, inv_sr, inv_d}, 3'b010);
        9:  check("inv_ph3_drive", {inv_en, inv_sr, inv_d}, 3'b011);
        12: begin
          check("inv_done", {inv_busy, inv_done, inv_pass}, 3'b011);
          check("inv_idle_drive", {inv_en, inv_sr, inv_d}, 3'b110);
        end
        default: ;
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
